// File: rtl/disp_scan_capture.sv
// disp_scan_capture
// Rebuilds the 16-bit four-digit word from a multiplexed 7-segment digit bus
// (Hex nibble + active-low AN strobes). A digit is captured once {AN,Hex} has
// stayed unchanged for SETTLE edges. The fourth distinct digit completes the
// frame and updates Hexs.
// Optional feature: define DISP_CAP_ERR_EN to get a sticky err flag. It is set
// when the bus settles on a strobe pattern that is neither one-cold nor blank.
// Without the macro, err is tied low and such patterns are treated as blank.
module disp_scan_capture #(
   parameter int unsigned SETTLE = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  Hex,
   input  logic [3:0]  AN,
   output logic [15:0] Hexs,
   output logic [3:0]  digit_mask,
   output logic        frame_valid,
   output logic        err
);

   typedef enum logic [1:0] {
      ST_WAIT    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_HOLD    = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_V = 4'(SETTLE);
   localparam logic [3:0] BLANK    = 4'b1111;

   // Bus sample registers and settle tracking
   logic [3:0]  an_q;
   logic [3:0]  hex_q;
   logic [3:0]  stab_reg;
   logic [3:0]  stab_next;
   state_t      state_reg;
   state_t      state_next;

   // Frame assembly
   logic [15:0] shadow_reg;
   logic [15:0] shadow_next;
   logic [3:0]  mask_reg;
   logic [3:0]  mask_set;
   logic [15:0] hexs_reg;
   logic        fv_reg;

   // Decode helpers
   logic        change;
   logic        capture_fire;
   logic [3:0]  sel;
   logic        one_cold;
   logic        complete;

   // A change is seen when the value about to be registered differs from the
   // value currently held. Using that same comparison here means stab and the
   // FSM restart on the edge where an_q/hex_q take the new pair.
   assign change = ({AN, Hex} != {an_q, hex_q});

   // Capture only happens if the bus is still stable as CAPTURE is left.
   // Otherwise the digit is dropped as a whole, with no partial capture.
   assign capture_fire = (state_reg == ST_CAPTURE) && !change;

   // One-cold decode of the registered strobes, one bit per digit position
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         localparam logic [3:0] ONE_COLD = ~(4'b0001 << gi);
         assign sel[gi] = (an_q == ONE_COLD);
         assign shadow_next[4*gi +: 4] = (capture_fire && sel[gi]) ? hex_q
                                                                   : shadow_reg[4*gi +: 4];
      end
   endgenerate

   assign one_cold = |sel;
   assign mask_set = mask_reg | (capture_fire ? sel : 4'b0000);
   assign complete = capture_fire && one_cold && (mask_set == 4'b1111);

   // Input sample registers; blank strobes and a zero nibble out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an_q  <= BLANK;
         hex_q <= 4'h0;
      end else begin
         an_q  <= AN;
         hex_q <= Hex;
      end
   end

   // Settle counter next value: clear on change, otherwise count up to SETTLE
   always_comb begin
      stab_next = stab_reg;
      if (change) begin
         stab_next = 4'd0;
      end else if (stab_reg != SETTLE_V) begin
         stab_next = stab_reg + 4'd1;
      end
   end

   // Settle counter register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stab_reg <= 4'd0;
      end else begin
         stab_reg <= stab_next;
      end
   end

   // Next-state logic. CAPTURE is entered on the edge where stab reaches
   // SETTLE, so it lasts one cycle. HOLD then blocks any re-capture until the
   // bus moves again.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_WAIT: begin
            if (!change && (stab_next == SETTLE_V)) begin
               state_next = ST_CAPTURE;
            end
         end
         ST_CAPTURE: begin
            state_next = change ? ST_WAIT : ST_HOLD;
         end
         ST_HOLD: begin
            if (change) begin
               state_next = ST_WAIT;
            end
         end
         default: begin
            state_next = ST_WAIT;
         end
      endcase
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_WAIT;
      end else begin
         state_reg <= state_next;
      end
   end

   // Frame assembly. The shadow collects nibbles and keeps them across
   // frames. The mask clears on the edge that completes a frame, and that
   // same edge publishes the shadow (with the newest nibble) to Hexs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_reg <= 16'h0000;
         mask_reg   <= 4'b0000;
         hexs_reg   <= 16'h0000;
         fv_reg     <= 1'b0;
      end else begin
         shadow_reg <= shadow_next;
         mask_reg   <= complete ? 4'b0000 : mask_set;
         fv_reg     <= complete;
         if (complete) begin
            hexs_reg <= shadow_next;
         end
      end
   end

`ifdef DISP_CAP_ERR_EN
   logic err_reg;
   logic illegal;

   assign illegal = !one_cold && (an_q != BLANK);

   // Sticky flag for a settled strobe pattern that is neither one-cold nor blank
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_reg <= 1'b0;
      end else if (capture_fire && illegal) begin
         err_reg <= 1'b1;
      end
   end

   assign err = err_reg;
`else
   assign err = 1'b0;
`endif

   assign Hexs        = hexs_reg;
   assign digit_mask  = mask_reg;
   assign frame_valid = fv_reg;

endmodule

// File: doc/disp_scan_capture.md
# disp_scan_capture

Receive-side counterpart of the scoreboard's 7-segment scan multiplexer. It watches the multiplexed digit bus (`Hex` plus active-low `AN` strobes) and rebuilds the 16-bit four-digit word the multiplexer was driven with. It sits beside the display path on the scoreboard and serves two purposes: readback and self-check of what is actually being shown, and a bench monitor for the display chain.

## Interface
- `SETTLE`, default 4: number of clock edges `{AN,Hex}` must hold unchanged before a digit is captured. Legal range is 1..15.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `Hex`  in  4  nibble currently on the digit bus.
- `AN`  in  4  active-low digit enables. Mapping:
  - 4'b1110 selects `Hexs[3:0]`
  - 4'b1101 selects `[7:4]`
  - 4'b1011 selects `[11:8]`
  - 4'b0111 selects `[15:12]`
  - 4'b1111 means blank.
- `Hexs`  out  16  last complete reconstructed frame.
- `digit_mask`  out  4  digits captured so far in the frame being assembled. Bit i is set once the nibble for `Hexs[4i+3:4i]` has been captured.
- `frame_valid`  out  1  one-cycle pulse when `Hexs` updates.
- `err`  out  1  sticky illegal-strobe flag. Only present with `DISP_CAP_ERR_EN`.

## Operation
- **Input registers.** `an_q`/`hex_q` sample `AN`/`Hex` every edge.
  - Reset values: `an_q`=4'b1111, `hex_q`=0.
- **Settle counter.** A 4-bit `stab` counter tracks how long `{an_q,hex_q}` has been unchanged.
  - It resets to 0 on any change of `{an_q,hex_q}`.
  - Otherwise it increments, saturating at `SETTLE`.
- **State machine.**
  - WAIT: counting. When `stab` reaches `SETTLE`, go to CAPTURE.
  - CAPTURE: lasts one cycle. The capture action is performed, then go to HOLD.
  - HOLD: no further capture. Go to WAIT on any change of `{an_q,hex_q}`.
  - Any change of `{an_q,hex_q}` while in WAIT or CAPTURE returns to WAIT with `stab`=0. There is no partial capture.
- **Capture action.**
  - `an_q` one-cold: write `hex_q` into the shadow nibble and set the matching `digit_mask` bit.
  - Re-capturing a digit already in the mask overwrites that shadow nibble. It is not an error.
  - `an_q`=4'b1111: no capture, no error.
- **Frame completion.** When a capture makes `digit_mask` 4'b1111:
  - `Hexs` loads the shadow (including the nibble just captured).
  - `frame_valid` pulses for one cycle.
  - `digit_mask` clears to 0 on the same edge.
  - The shadow keeps its contents.
- **Reset.** All outputs are 0: `Hexs`=16'h0000, `digit_mask`=0, `frame_valid`=0, `err`=0. State is WAIT, `stab`=0, shadow=0.
  - Reset mid-frame discards the partial frame.
  - `Hexs` holds its last value between frames; only reset clears it.

## Timing
- Let E0 be the edge at which a new `{AN,Hex}` pair is first registered into `an_q`/`hex_q`.
- The state enters CAPTURE at edge E0+`SETTLE`.
- `digit_mask`/shadow update at edge E0+`SETTLE`+1.
- A completing capture makes `Hexs` and `frame_valid` visible in the cycle after edge E0+`SETTLE`+1, i.e. 2+`SETTLE` edges after the input change.
- Minimum digit dwell for capture is `SETTLE`+2 cycles. Shorter dwells are ignored silently.
- A stable period captures exactly once, however long it lasts.
- `frame_valid` is never high on two consecutive cycles. The minimum frame spacing is 4×(`SETTLE`+2) cycles.

## Configuration
- `DISP_CAP_ERR_EN` defined: on CAPTURE, any `an_q` pattern that is neither one-cold nor 4'b1111 sets `err`.
  - `err` stays high until reset.
  - Mask and shadow are unchanged by the illegal pattern.
- `DISP_CAP_ERR_EN` undefined:
  - `err` is tied 0.
  - Illegal patterns are ignored exactly like blank.

## Test plan
- **Full frame.** Hold `Hex` at 9,3,6,C with `AN` at 1110,1101,1011,0111, 8 cycles each, `SETTLE`=4 → `Hexs`=16'hC639 and a single `frame_valid` pulse. `digit_mask` steps 0001→0011→0111→0 (all four bits are set on the 4th capture and cleared on the same edge, so 1111 is never visible).
- **Glitch rejection.** Hold `AN`=1101 for 3 cycles, then `AN`=1110/`Hex`=5 for 8 cycles → only bit 0 is set and shadow[3:0]=5. No capture of digit 1.
- **Blank and re-capture.** Insert `AN`=1111 between digits, and repeat digit 0 with `Hex`=A before digit 3 arrives → no effect from the blank, frame completes with `Hexs[3:0]`=4'hA.
- **Illegal strobe.** Hold `AN`=1001 for 8 cycles → `err`=1 with macro defined, `err`=0 without. `digit_mask` is unchanged in both cases.
- **Reset mid-frame.** Pulse `rst` after two digits have been captured, then send a full frame of 1,2,3,4 → after the pulse `digit_mask`=0 and `Hexs`=0. The frame then yields `Hexs`=16'h4321 with exactly one `frame_valid`.
- **Long dwell.** Hold a single digit for 100 cycles → exactly one capture. The mask bit sets once and no extra `frame_valid` occurs.
